// File: rtl/neo_pkg.sv
// Shared types and helpers for the NEO frame sequencer.
package neo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } neo_state_t;

  // Number of taps in the x[n-1], x[n], x[n+1] window.
  localparam int unsigned NEO_PIPE_DEPTH = 3;

  // Address width for a frame of m samples; one spare bit above $clog2(m).
  function automatic int neo_aw(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/neo_seq_ctrl_if.sv
// Host / sample-memory / result-memory signals of the NEO sequencer.
interface neo_seq_ctrl_if #(
  parameter int N  = 16,
  parameter int AW = 5
);
  logic                 start;
  logic                 abort;
  logic [AW-1:0]        raddr;
  logic signed [N-1:0]  rdata;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic signed [N-1:0]  wdata;
  logic                 busy;
  logic                 done;

  // Host and memory side: issues start/abort, returns read data.
  modport master (
    output start, abort, rdata,
    input  raddr, we, waddr, wdata, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, abort, rdata,
    output raddr, we, waddr, wdata, busy, done
  );
endinterface

// File: rtl/neo_core.sv
// Registered NEO arithmetic: psi = x1^2 - x0*x2, arithmetic shift, saturate to N bits.
module neo_core #(
  parameter int N     = 16,
  parameter int SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] x0,
  input  logic signed [N-1:0] x1,
  input  logic signed [N-1:0] x2,
  input  logic                in_valid,
  output logic signed [N-1:0] psi_sat,
  output logic                out_valid
);

  localparam logic signed [2*N:0] MAX_V = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0] MIN_V = {{(N+2){1'b1}}, {(N-1){1'b0}}};

  logic signed [2*N-1:0] x0_ext;
  logic signed [2*N-1:0] x1_ext;
  logic signed [2*N-1:0] x2_ext;
  logic signed [2*N-1:0] sq;
  logic signed [2*N-1:0] xp;
  logic signed [2*N:0]   psi;
  logic signed [2*N:0]   psi_sh;
  logic signed [N-1:0]   sat;

  // Full-precision energy term, then scale and clamp into the result width.
  always_comb begin
    x0_ext = {{N{x0[N-1]}}, x0};
    x1_ext = {{N{x1[N-1]}}, x1};
    x2_ext = {{N{x2[N-1]}}, x2};
    sq     = x1_ext * x1_ext;
    xp     = x0_ext * x2_ext;
    psi    = {sq[2*N-1], sq} - {xp[2*N-1], xp};
    psi_sh = psi >>> SHIFT;
    if (psi_sh > MAX_V) begin
      sat = MAX_V[N-1:0];
    end else if (psi_sh < MIN_V) begin
      sat = MIN_V[N-1:0];
    end else begin
      sat = psi_sh[N-1:0];
    end
  end

  // Output register; result is forced to zero whenever it is not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      psi_sat   <= '0;
    end else begin
      out_valid <= in_valid;
      psi_sat   <= in_valid ? sat : '0;
    end
  end

endmodule

// File: rtl/neo_seq_ctrl.sv
// Frame sequencer: streams M samples, forms the 3-tap window and writes psi[1..M-2].
module neo_seq_ctrl
  import neo_pkg::*;
#(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int SHIFT = 0
) (
  input  logic          Clk,
  input  logic          reset,
  neo_seq_ctrl_if.slave bus
);

  localparam int AW = neo_aw(M);
  localparam int CW = $clog2(NEO_PIPE_DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(NEO_PIPE_DEPTH);
  localparam logic [CW-1:0] CNT_PRIME = CW'(NEO_PIPE_DEPTH - 1);

  if (M < 3) begin : g_bad_m
    $error("neo_seq_ctrl: M must be >= 3");
  end

  neo_state_t state;
  neo_state_t state_next;

  logic                frame_start;
  logic                frame_kill;
  logic                last_addr;
  logic                drain_empty;

  logic [AW-1:0]       rd_addr;
  logic                rd_pend;

  logic signed [N-1:0] win [NEO_PIPE_DEPTH];
  logic [CW-1:0]       win_cnt;
  logic                win_fresh;

  logic [AW-1:0]       res_idx;
  logic [AW-1:0]       wr_addr;
  logic                done_q;

  logic                core_in_valid;
  logic                core_valid;
  logic signed [N-1:0] core_psi;

  // Next-state decode; abort only matters once a frame is running.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_kill  = 1'b0;
    last_addr   = (rd_addr == LAST_ADDR);
    drain_empty = !rd_pend && !win_fresh;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next  = READ;
          frame_start = 1'b1;
        end
      end
      READ: begin
        if (bus.abort) begin
          state_next = IDLE;
          frame_kill = 1'b1;
        end else if (last_addr) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_next = IDLE;
          frame_kill = 1'b1;
        end else if (drain_empty) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read address counter; rd_pend marks the cycle rdata belongs to this frame.
  always_ff @(posedge Clk) begin
    if (reset) begin
      rd_addr <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= (state == READ) && !bus.abort;
      if ((state == READ) && !bus.abort && !last_addr) begin
        rd_addr <= rd_addr + AW'(1);
      end else begin
        rd_addr <= '0;
      end
    end
  end

  // Sample window; emptied at every frame start and on abort so frames never mix.
  always_ff @(posedge Clk) begin
    if (reset || frame_start || frame_kill) begin
      win       <= '{default: '0};
      win_cnt   <= '0;
      win_fresh <= 1'b0;
    end else if (rd_pend) begin
      for (int unsigned i = 0; i < NEO_PIPE_DEPTH - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[NEO_PIPE_DEPTH-1] <= bus.rdata;
      win_cnt   <= (win_cnt == CNT_FULL) ? win_cnt : win_cnt + CW'(1);
      win_fresh <= (win_cnt >= CNT_PRIME);
    end else begin
      win_fresh <= 1'b0;
    end
  end

  assign core_in_valid = win_fresh && !frame_kill;

  neo_core #(
    .N     (N),
    .SHIFT (SHIFT)
  ) u_core (
    .clk       (Clk),
    .rst       (reset),
    .x0        (win[0]),
    .x1        (win[1]),
    .x2        (win[2]),
    .in_valid  (core_in_valid),
    .psi_sat   (core_psi),
    .out_valid (core_valid)
  );

  // Result index travels alongside the core register so it lines up with psi.
  always_ff @(posedge Clk) begin
    if (reset || frame_start) begin
      res_idx <= AW'(1);
      wr_addr <= '0;
    end else if (core_in_valid) begin
      res_idx <= res_idx + AW'(1);
      wr_addr <= res_idx;
    end
  end

  // Done fires the cycle after the drain completes without an abort.
  always_ff @(posedge Clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == DRAIN) && !bus.abort && drain_empty;
    end
  end

  assign bus.raddr = rd_addr;
  assign bus.we    = core_valid;
  assign bus.waddr = core_valid ? wr_addr : '0;
  assign bus.wdata = core_valid ? core_psi : '0;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_neo_seq_ctrl.sv
// Self-checking bench for neo_seq_ctrl: two instances (SHIFT=0 and SHIFT=4) share one sample memory.
module tb_neo_seq_ctrl;
  import neo_pkg::*;

  localparam int N  = 16;
  localparam int M  = 16;
  localparam int AW = neo_aw(M);

  typedef struct {
    int raddr;
    bit we;
    int waddr;
    int wdata;
    bit busy;
    bit done;
  } smp_t;

  logic clk;
  logic reset;
  logic start;
  logic abort;
  logic rec;
  logic signed [N-1:0] mem [M];

  smp_t h0[$];
  smp_t h4[$];

  int total;
  int bad;

  neo_seq_ctrl_if #(.N(N), .AW(AW)) bus0 ();
  neo_seq_ctrl_if #(.N(N), .AW(AW)) bus4 ();

  assign bus0.start = start;
  assign bus0.abort = abort;
  assign bus4.start = start;
  assign bus4.abort = abort;

  neo_seq_ctrl #(.N(N), .M(M), .SHIFT(0)) dut0 (
    .Clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  neo_seq_ctrl #(.N(N), .M(M), .SHIFT(4)) dut4 (
    .Clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample memories with 1-cycle registered read.
  always @(posedge clk) begin
    bus0.rdata <= mem[bus0.raddr[3:0]];
    bus4.rdata <= mem[bus4.raddr[3:0]];
  end

  // Per-cycle history, index = cycle number relative to the start cycle.
  always @(negedge clk) begin
    if (rec) begin
      h0.push_back('{int'(bus0.raddr), bus0.we, int'(bus0.waddr), int'(bus0.wdata), bus0.busy, bus0.done});
      h4.push_back('{int'(bus4.raddr), bus4.we, int'(bus4.waddr), int'(bus4.wdata), bus4.busy, bus4.done});
    end
  end

  // Reference: psi[n] from the window definition, shifted and clamped.
  function automatic int model(input int n, input int s);
    longint a, b, c, p;
    a = mem[n-1];
    b = mem[n];
    c = mem[n+1];
    p = b * b - a * c;
    p = p >>> s;
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return int'(p);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < M; i++) begin
      if ($urandom_range(0, 1) == 1) mem[i] = 16'($urandom);
      else mem[i] = 16'($urandom_range(0, 400)) - 16'sd200;
    end
  endtask

  // Runs ncyc cycles from the start pulse in cycle 0; other events at given cycles (-1 = none).
  task automatic run_frame(input int ncyc, input int abort_at, input int start2_at,
                           input int start3_at, input int rst_at);
    h0.delete();
    h4.delete();
    rec = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == start2_at) || (c == start3_at);
      abort = (c == abort_at);
      reset = (rst_at >= 0) && ((c == rst_at) || (c == rst_at + 1));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    rec   = 1'b0;
  endtask

  task automatic test_reset();
    smp_t h[$];
    int act;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus0.raddr, bus0.we, bus0.waddr, bus0.wdata, bus0.busy, bus0.done} !== '0) begin
      bad++;
      $display("FAIL reset_idle dut0 got raddr=%0d we=%0b waddr=%0d wdata=%0d busy=%0b done=%0b want all 0",
               bus0.raddr, bus0.we, bus0.waddr, bus0.wdata, bus0.busy, bus0.done);
    end
    total++;
    if ({bus4.raddr, bus4.we, bus4.waddr, bus4.wdata, bus4.busy, bus4.done} !== '0) begin
      bad++;
      $display("FAIL reset_idle dut4 got raddr=%0d we=%0b waddr=%0d wdata=%0d busy=%0b done=%0b want all 0",
               bus4.raddr, bus4.we, bus4.waddr, bus4.wdata, bus4.busy, bus4.done);
    end
    reset = 1'b0;
    for (int i = 0; i < M; i++) mem[i] = 16'(i);
    run_frame(30, -1, -1, -1, 4);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) h = h0; else h = h4;
      total++;
      if (!(h[4].busy == 1'b1 && h[4].raddr == 3)) begin
        bad++;
        $display("FAIL reset_midread dut%0d got busy=%0b raddr=%0d want busy=1 raddr=3", d, h[4].busy, h[4].raddr);
      end
      total++;
      if (h[6].raddr != 0 || h[6].we || h[6].waddr != 0 || h[6].wdata != 0 || h[6].busy || h[6].done) begin
        bad++;
        $display("FAIL reset_outputs dut%0d got raddr=%0d we=%0b waddr=%0d wdata=%0d busy=%0b done=%0b want all 0",
                 d, h[6].raddr, h[6].we, h[6].waddr, h[6].wdata, h[6].busy, h[6].done);
      end
      act = 0;
      for (int c = 5; c < 30; c++) if (h[c].we || h[c].busy || h[c].done) act++;
      total++;
      if (act != 0) begin
        bad++;
        $display("FAIL reset_quiet dut%0d got %0d active cycles want 0", d, act);
      end
    end
  endtask

  task automatic test_ramp();
    smp_t h[$];
    int nw;
    bit ew, eb, ed;
    int ea, edat, er;
    for (int i = 0; i < M; i++) mem[i] = 16'(i);
    run_frame(24, -1, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) h = h0; else h = h4;
      nw = 0;
      for (int c = 0; c < 24; c++) begin
        ew   = (c >= 6) && (c <= M + 3);
        ea   = ew ? c - 5 : 0;
        edat = ew ? model(c - 5, d * 4) : 0;
        eb   = (c >= 1) && (c <= M + 3);
        ed   = (c == M + 4);
        er   = ((c >= 1) && (c <= M)) ? c - 1 : 0;
        if (h[c].we) nw++;
        total++;
        if (h[c].we != ew || h[c].waddr != ea || h[c].wdata != edat ||
            h[c].busy != eb || h[c].done != ed || h[c].raddr != er) begin
          bad++;
          $display("FAIL ramp_cycle dut%0d c=%0d got we=%0b waddr=%0d wdata=%0d busy=%0b done=%0b raddr=%0d want %0b %0d %0d %0b %0b %0d",
                   d, c, h[c].we, h[c].waddr, h[c].wdata, h[c].busy, h[c].done, h[c].raddr,
                   ew, ea, edat, eb, ed, er);
        end
      end
      total++;
      if (nw != M - 2) begin
        bad++;
        $display("FAIL ramp_count dut%0d got %0d writes want %0d", d, nw, M - 2);
      end
    end
    total++;
    if (h0[6].wdata != 1 || h0[19].wdata != 1) begin
      bad++;
      $display("FAIL ramp_value got first=%0d last=%0d want 1 1", h0[6].wdata, h0[19].wdata);
    end
  endtask

  task automatic test_saturation();
    int tn[5] = '{1, 2, 3, 4, 5};
    int t0[5] = '{32767, 32767, -32768, 32767, 10000};
    int t4[5] = '{32767, 32767, -32768, 5000, 625};
    for (int i = 0; i < M; i++) mem[i] = '0;
    mem[0] = -16'sd32768;
    mem[1] = 16'sd0;
    mem[2] = 16'sd32767;
    mem[3] = 16'sd100;
    mem[4] = 16'sd300;
    mem[5] = 16'sd100;
    run_frame(24, -1, -1, -1, -1);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (!h0[tn[i] + 5].we || h0[tn[i] + 5].wdata != t0[i]) begin
        bad++;
        $display("FAIL sat_shift0 n=%0d got we=%0b wdata=%0d want 1 %0d", tn[i], h0[tn[i] + 5].we, h0[tn[i] + 5].wdata, t0[i]);
      end
      total++;
      if (!h4[tn[i] + 5].we || h4[tn[i] + 5].wdata != t4[i]) begin
        bad++;
        $display("FAIL sat_shift4 n=%0d got we=%0b wdata=%0d want 1 %0d", tn[i], h4[tn[i] + 5].we, h4[tn[i] + 5].wdata, t4[i]);
      end
    end
  endtask

  task automatic test_negative();
    int tn[6] = '{1, 2, 3, 4, 5, 6};
    int t0[6] = '{100, 0, 32767, -975, -24, 25};
    int t4[6] = '{6, 0, 32767, -61, -2, 1};
    int v[7]  = '{0, 10, 100, 1000, 5, 1, 5};
    for (int i = 0; i < M; i++) mem[i] = '0;
    for (int i = 0; i < 7; i++) mem[i] = 16'(v[i]);
    run_frame(24, -1, -1, -1, -1);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (!h0[tn[i] + 5].we || h0[tn[i] + 5].wdata != t0[i]) begin
        bad++;
        $display("FAIL neg_shift0 n=%0d got we=%0b wdata=%0d want 1 %0d", tn[i], h0[tn[i] + 5].we, h0[tn[i] + 5].wdata, t0[i]);
      end
      total++;
      if (!h4[tn[i] + 5].we || h4[tn[i] + 5].wdata != t4[i]) begin
        bad++;
        $display("FAIL neg_shift4 n=%0d got we=%0b wdata=%0d want 1 %0d", tn[i], h4[tn[i] + 5].we, h4[tn[i] + 5].wdata, t4[i]);
      end
    end
  endtask

  task automatic test_abort();
    smp_t h[$];
    int late, dn, errs;
    fill_random();
    run_frame(24, 8, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) h = h0; else h = h4;
      late = 0;
      dn = 0;
      for (int c = 9; c < 24; c++) if (h[c].we) late++;
      for (int c = 0; c < 24; c++) if (h[c].done) dn++;
      total++;
      if (!(h[8].we == 1'b1 && h[8].waddr == 3)) begin
        bad++;
        $display("FAIL abort_inflight dut%0d got we=%0b waddr=%0d want 1 3", d, h[8].we, h[8].waddr);
      end
      total++;
      if (late != 0 || dn != 0 || h[9].busy != 1'b0) begin
        bad++;
        $display("FAIL abort_stop dut%0d got late_writes=%0d dones=%0d busy9=%0b want 0 0 0", d, late, dn, h[9].busy);
      end
    end
    fill_random();
    run_frame(24, -1, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) h = h0; else h = h4;
      errs = 0;
      for (int n = 1; n <= M - 2; n++) begin
        if (!h[n + 5].we || h[n + 5].waddr != n || h[n + 5].wdata != model(n, d * 4)) begin
          errs++;
          if (errs == 1)
            $display("FAIL abort_refill dut%0d n=%0d got we=%0b waddr=%0d wdata=%0d want 1 %0d %0d",
                     d, n, h[n + 5].we, h[n + 5].waddr, h[n + 5].wdata, n, model(n, d * 4));
        end
      end
      total++;
      if (errs != 0) bad++;
      total++;
      if (h[M + 4].done != 1'b1) begin
        bad++;
        $display("FAIL abort_refill_done dut%0d got %0b want 1", d, h[M + 4].done);
      end
    end
  endtask

  task automatic test_back_to_back();
    smp_t h[$];
    int nw, dn, errs;
    fill_random();
    run_frame(44, -1, 20, 10, -1);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) h = h0; else h = h4;
      total++;
      if (!(h[20].done && h[21].raddr == 0 && h[21].busy && h[22].raddr == 1)) begin
        bad++;
        $display("FAIL b2b_restart dut%0d got done20=%0b raddr21=%0d busy21=%0b raddr22=%0d want 1 0 1 1",
                 d, h[20].done, h[21].raddr, h[21].busy, h[22].raddr);
      end
      nw = 0;
      dn = 0;
      for (int c = 0; c < 44; c++) begin
        if (h[c].we) nw++;
        if (h[c].done) dn++;
      end
      total++;
      if (nw != 2 * (M - 2) || dn != 2 || !h[40].done) begin
        bad++;
        $display("FAIL b2b_count dut%0d got writes=%0d dones=%0d done40=%0b want %0d 2 1", d, nw, dn, h[40].done, 2 * (M - 2));
      end
      errs = 0;
      for (int n = 1; n <= M - 2; n++) begin
        if (h[n + 25].waddr != n || h[n + 25].wdata != model(n, d * 4)) errs++;
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL b2b_data dut%0d got %0d wrong second-frame writes want 0", d, errs);
      end
    end
  endtask

  task automatic test_random();
    smp_t h[$];
    int errs;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      run_frame(M + 6, -1, -1, -1, -1);
      for (int d = 0; d < 2; d++) begin
        if (d == 0) h = h0; else h = h4;
        errs = 0;
        for (int c = 0; c < M + 6; c++) begin
          if (c >= 6 && c <= M + 3) begin
            if (!h[c].we || h[c].waddr != c - 5 || h[c].wdata != model(c - 5, d * 4)) begin
              errs++;
              if (errs == 1)
                $display("FAIL rand_write dut%0d frame=%0d c=%0d got we=%0b waddr=%0d wdata=%0d want 1 %0d %0d",
                         d, f, c, h[c].we, h[c].waddr, h[c].wdata, c - 5, model(c - 5, d * 4));
            end
          end else if (h[c].we || h[c].waddr != 0 || h[c].wdata != 0) begin
            errs++;
            if (errs == 1)
              $display("FAIL rand_idle dut%0d frame=%0d c=%0d got we=%0b waddr=%0d wdata=%0d want 0 0 0",
                       d, f, c, h[c].we, h[c].waddr, h[c].wdata);
          end
        end
        total++;
        if (errs != 0) bad++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rec   = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < M; i++) mem[i] = '0;
    test_reset();
    test_ramp();
    test_saturation();
    test_negative();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
